// File: rtl/count_capture_pkg.sv
// Shared widths and the capture entry layout for the count capture FIFO.
package count_capture_pkg;
   localparam int WIDTH_DEF  = 32;
   localparam int DROP_CNT_W = 16;

   typedef struct packed {
      logic [WIDTH_DEF-1:0] stamp;
      logic [WIDTH_DEF-1:0] delta;
   } cap_entry_t;
endpackage

// File: rtl/count_fifo.sv
// Generic synchronous FIFO with exact occupancy count and a registered head entry.
module count_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [W-1:0]           din,
   input  logic                   pop,
   output logic [W-1:0]           head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_inc;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign full   = (cnt == FULL_LVL);
   assign empty  = (cnt == '0);
   assign level  = cnt;
   assign rd_inc = rd_ptr + AW'(1);

   // Push into a full FIFO is legal only when the head leaves on the same edge.
   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
   end

   // Storage array; no reset needed since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers, occupancy and the registered head entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         head   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_inc;
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + ONE_LVL;
            2'b01:   cnt <= cnt - ONE_LVL;
            default: cnt <= cnt;
         endcase
         // Head follows the next entry; when the queue drains it keeps the last value.
         if (do_pop) begin
            if (cnt == ONE_LVL) begin
               if (do_push) begin
                  head <= din;
               end
            end else begin
               head <= mem[rd_inc];
            end
         end else if (do_push && empty) begin
            head <= din;
         end
      end
   end
endmodule

// File: rtl/count_capture_fifo.sv
// Timestamps trigger events with the upstream count, computes the inter-event
// interval and queues {stamp, delta} pairs; counts events lost to a full queue.
module count_capture_fifo
   import count_capture_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int DEPTH     = 8,
   parameter int EDGE_MODE = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       count,
   input  logic                   trig,
   input  logic                   clr_ovf,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       out_stamp,
   output logic [WIDTH-1:0]       out_delta,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   output logic [DROP_CNT_W-1:0]  drop_cnt
);
   localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

   logic               trig_q;
   logic               first;
   logic [WIDTH-1:0]   last_stamp;
   logic               cap_event;
   logic               pop;
   logic               accept;
   logic               drop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [WIDTH-1:0]   delta;
   logic [2*WIDTH-1:0] head;

   // Event qualification and accept/drop decision against current occupancy.
   always_comb begin
      if (EDGE_MODE != 0) begin
         cap_event = trig && !trig_q;
      end else begin
         cap_event = trig;
      end
      pop    = out_valid && out_ready;
      accept = cap_event && (!fifo_full || pop);
      drop   = cap_event && fifo_full && !pop;
      if (first) begin
         delta = '0;
      end else begin
         delta = count - last_stamp;
      end
   end

   count_fifo #(
      .W     (2*WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .din   ({count, delta}),
      .pop   (pop),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   assign out_valid = !fifo_empty;
   assign out_stamp = head[2*WIDTH-1:WIDTH];
   assign out_delta = head[WIDTH-1:0];

   // Interval reference only advances on accepted events, so drops widen the next delta.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trig_q     <= 1'b0;
         first      <= 1'b1;
         last_stamp <= '0;
      end else begin
         trig_q <= trig;
         if (accept) begin
            last_stamp <= count;
            first      <= 1'b0;
         end
      end
   end

   // Drop accounting; a drop in the clear cycle takes priority over the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clr_ovf) begin
            drop_cnt <= DROP_CNT_W'(1);
         end else if (drop_cnt != DROP_MAX) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
         end
      end else if (clr_ovf) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end
   end
endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed bench for count_capture_fifo: an edge-mode and a level-mode instance share stimulus.
module tb_count_capture_fifo;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] count;
   logic        trig;
   logic        clr_ovf;
   logic        out_ready;

   logic        v1, v0;
   logic [31:0] s1, d1, s0, d0;
   logic [3:0]  l1, l0;
   logic        o1, o0;
   logic [15:0] c1, c0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   count_capture_fifo #(.WIDTH(32), .DEPTH(8), .EDGE_MODE(1)) dut_edge (
      .clk(clk), .rst(rst), .count(count), .trig(trig), .clr_ovf(clr_ovf),
      .out_ready(out_ready), .out_valid(v1), .out_stamp(s1), .out_delta(d1),
      .level(l1), .overflow(o1), .drop_cnt(c1)
   );

   count_capture_fifo #(.WIDTH(32), .DEPTH(8), .EDGE_MODE(0)) dut_lvl (
      .clk(clk), .rst(rst), .count(count), .trig(trig), .clr_ovf(clr_ovf),
      .out_ready(out_ready), .out_valid(v0), .out_stamp(s0), .out_delta(d0),
      .level(l0), .overflow(o0), .drop_cnt(c0)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; the counter advances just after the edge, like the upstream counter.
   task automatic cyc();
      @(posedge clk);
      #1;
      count = count + 32'd1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      trig = 1'b0;
      clr_ovf = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      count = 32'd0;
   endtask

   task automatic pulse_at(input logic [31:0] n);
      while (count != n) cyc();
      trig = 1'b1;
      cyc();
      trig = 1'b0;
   endtask

   initial begin
      count = 32'd0;
      trig = 1'b0;
      clr_ovf = 1'b0;
      out_ready = 1'b0;
      rst = 1'b1;
      #12;
      chk("rst_valid", {63'd0, v1}, 64'd0);
      chk("rst_stamp", {32'd0, s1}, 64'd0);
      chk("rst_delta", {32'd0, d1}, 64'd0);
      chk("rst_level", {60'd0, l1}, 64'd0);
      chk("rst_ovf",   {63'd0, o1}, 64'd0);
      chk("rst_drop",  {48'd0, c1}, 64'd0);

      // Single capture, visible one cycle later
      do_reset();
      pulse_at(32'd5);
      chk("t1_valid", {63'd0, v1}, 64'd1);
      chk("t1_stamp", {32'd0, s1}, 64'd5);
      chk("t1_delta", {32'd0, d1}, 64'd0);
      chk("t1_level", {60'd0, l1}, 64'd1);
      out_ready = 1'b1;
      cyc();
      chk("t1_empty", {63'd0, v1}, 64'd0);
      chk("t1_hold",  {32'd0, s1}, 64'd5);

      // Three queued events, back-to-back drain
      do_reset();
      pulse_at(32'd5);
      pulse_at(32'd12);
      pulse_at(32'd30);
      chk("t2_level", {60'd0, l1}, 64'd3);
      chk("t2_stall_stamp", {32'd0, s1}, 64'd5);
      out_ready = 1'b1;
      chk("t2_d0", {32'd0, d1}, 64'd0);
      cyc();
      chk("t2_s1", {32'd0, s1}, 64'd12);
      chk("t2_d1", {32'd0, d1}, 64'd7);
      cyc();
      chk("t2_s2", {32'd0, s1}, 64'd30);
      chk("t2_d2", {32'd0, d1}, 64'd18);
      cyc();
      chk("t2_empty", {63'd0, v1}, 64'd0);
      chk("t2_level0", {60'd0, l1}, 64'd0);

      // Trigger held for four cycles: edge vs level capture
      do_reset();
      while (count != 32'd40) cyc();
      trig = 1'b1;
      repeat (4) cyc();
      trig = 1'b0;
      chk("t3_edge_level", {60'd0, l1}, 64'd1);
      chk("t3_edge_stamp", {32'd0, s1}, 64'd40);
      chk("t3_lvl_level",  {60'd0, l0}, 64'd4);
      chk("t3_lvl_s0", {32'd0, s0}, 64'd40);
      chk("t3_lvl_d0", {32'd0, d0}, 64'd0);
      out_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         cyc();
         chk("t3_lvl_s", {32'd0, s0}, 64'(40 + i));
         chk("t3_lvl_d", {32'd0, d0}, 64'd1);
      end
      chk("t3_edge_drained", {63'd0, v1}, 64'd0);
      cyc();
      chk("t3_lvl_drained", {63'd0, v0}, 64'd0);

      // Overflow: 11 events into 8 slots, stamps 2..16 kept, 18..22 dropped
      do_reset();
      for (int i = 1; i <= 11; i++) pulse_at(32'(2 * i));
      chk("t4_level", {60'd0, l1}, 64'd8);
      chk("t4_ovf",   {63'd0, o1}, 64'd1);
      chk("t4_drop",  {48'd0, c1}, 64'd3);
      chk("t4_head",  {32'd0, s1}, 64'd2);
      out_ready = 1'b1;
      repeat (8) cyc();
      chk("t4_drained", {63'd0, v1}, 64'd0);
      pulse_at(32'd40);
      chk("t4_after_stamp", {32'd0, s1}, 64'd40);
      chk("t4_after_delta", {32'd0, d1}, 64'd24);
      cyc();
      clr_ovf = 1'b1;
      cyc();
      clr_ovf = 1'b0;
      chk("t4_clr_ovf",  {63'd0, o1}, 64'd0);
      chk("t4_clr_drop", {48'd0, c1}, 64'd0);
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) pulse_at(32'(50 + 2 * i));
      chk("t4_refill", {60'd0, l1}, 64'd8);
      while (count != 32'd70) cyc();
      trig = 1'b1;
      clr_ovf = 1'b1;
      cyc();
      trig = 1'b0;
      clr_ovf = 1'b0;
      chk("t4_dropwins_ovf",  {63'd0, o1}, 64'd1);
      chk("t4_dropwins_cnt",  {48'd0, c1}, 64'd1);
      cyc();
      out_ready = 1'b1;
      trig = 1'b1;
      cyc();
      trig = 1'b0;
      out_ready = 1'b0;
      chk("t4_full_pushpop_level", {60'd0, l1}, 64'd8);
      chk("t4_full_pushpop_drop",  {48'd0, c1}, 64'd1);
      chk("t4_full_pushpop_head",  {32'd0, s1}, 64'd52);

      // Counter wrap between captures
      do_reset();
      count = 32'hFFFF_FFF0;
      trig = 1'b1;
      cyc();
      trig = 1'b0;
      cyc();
      count = 32'h0000_0010;
      trig = 1'b1;
      cyc();
      trig = 1'b0;
      chk("t5_level", {60'd0, l1}, 64'd2);
      out_ready = 1'b1;
      cyc();
      chk("t5_stamp", {32'd0, s1}, 64'h0000_0010);
      chk("t5_delta", {32'd0, d1}, 64'h0000_0020);

      // Asynchronous reset in the middle of a cycle
      do_reset();
      for (int i = 1; i <= 5; i++) pulse_at(32'(3 * i));
      chk("t6_level5", {60'd0, l1}, 64'd5);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_valid", {63'd0, v1}, 64'd0);
      chk("t6_async_level", {60'd0, l1}, 64'd0);
      chk("t6_async_lvl_valid", {63'd0, v0}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      count = 32'd0;
      pulse_at(32'd9);
      chk("t6_first_stamp", {32'd0, s1}, 64'd9);
      chk("t6_first_delta", {32'd0, d1}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
